neo_crom_arb: RTL

Arbiter and sequencer for the single SDRAM read port shared by sprite C-ROM fetches and fix-layer S-ROM fetches.
- Folds the 2-bit C-ROM bank from the NEO-CMC bank logic into the sprite word address.
- Grants one requester at a time and runs the SDRAM req/ack/valid handshake.
- Returns read data to the granted requester with a one-cycle ready strobe.
- Sits between the LSPC/fix fetch logic and the SDRAM controller.

---
 rtl/neo_crom_arb_if.sv | 31 +++
 rtl/neo_crom_arb.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/neo_crom_arb_if.sv
// Fetch-side and SDRAM-side signals of the C-ROM/S-ROM read-port arbiter.
// slave is the arbiter's view; master is the view of the logic driving it.
interface neo_crom_arb_if #(
  parameter int unsigned ADDR_W = 26
);
  logic              SPR_REQ;
  logic [23:0]       SPR_ADDR;
  logic [1:0]        SPR_BANK;
  logic [31:0]       SPR_DATA;
  logic              SPR_RDY;
  logic              FIX_REQ;
  logic [16:0]       FIX_ADDR;
  logic [15:0]       FIX_DATA;
  logic              FIX_RDY;
  logic              SD_REQ;
  logic [ADDR_W-1:0] SD_ADDR;
  logic              SD_ACK;
  logic              SD_VALID;
  logic [31:0]       SD_DATA;
  logic              TMO_ERR;

  modport slave (
    input  SPR_REQ, SPR_ADDR, SPR_BANK, FIX_REQ, FIX_ADDR, SD_ACK, SD_VALID, SD_DATA,
    output SPR_DATA, SPR_RDY, FIX_DATA, FIX_RDY, SD_REQ, SD_ADDR, TMO_ERR
  );

  modport master (
    output SPR_REQ, SPR_ADDR, SPR_BANK, FIX_REQ, FIX_ADDR, SD_ACK, SD_VALID, SD_DATA,
    input  SPR_DATA, SPR_RDY, FIX_DATA, FIX_RDY, SD_REQ, SD_ADDR, TMO_ERR
  );
endinterface

// File: rtl/neo_crom_arb.sv
// Shares the SDRAM read port between sprite C-ROM and fix S-ROM fetches.
// Optional WAIT timeout enabled by defining NEO_ARB_TIMEOUT_EN.
module neo_crom_arb #(
  parameter int unsigned       ADDR_W    = 26,
  parameter logic [ADDR_W-1:0] CROM_BASE = ADDR_W'(26'h0800000),
  parameter logic [ADDR_W-1:0] FIX_BASE  = ADDR_W'(26'h0040000),
  parameter int unsigned       TMO_CYC   = 63
) (
  input  logic CLK,
  input  logic nRESET,
  neo_crom_arb_if.slave bus
);

  localparam int unsigned TMO_W = 6;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            state;
  logic              spr_req_q, fix_req_q;
  logic              pend_spr, pend_fix;
  logic              last_spr;
  logic              gnt_spr;
  logic [ADDR_W-1:0] spr_wa, fix_wa;
  logic              fix_lsb, fix_lsb_g;
  logic              sd_req_q;
  logic [ADDR_W-1:0] sd_addr_q;
  logic [31:0]       spr_data_q;
  logic [15:0]       fix_data_q;
  logic              spr_rdy_q, fix_rdy_q;
  logic              tmo_err_q;

  logic              spr_edge_c, fix_edge_c, sel_spr_c;
  logic [ADDR_W-1:0] spr_wa_c, fix_wa_c;
  logic [15:0]       fix_word_c;
  logic              unused_c;

  assign spr_edge_c = bus.SPR_REQ & ~spr_req_q;
  assign fix_edge_c = bus.FIX_REQ & ~fix_req_q;
  // Round-robin: with both pending, the requester not served last wins
  assign sel_spr_c  = pend_spr & (~pend_fix | ~last_spr);
  assign spr_wa_c   = CROM_BASE + ADDR_W'({bus.SPR_BANK, bus.SPR_ADDR[23:1]});
  assign fix_wa_c   = FIX_BASE + ADDR_W'(bus.FIX_ADDR[16:1]);
  assign fix_word_c = fix_lsb_g ? bus.SD_DATA[31:16] : bus.SD_DATA[15:0];
  assign unused_c   = ^{bus.SPR_ADDR[0], TMO_W'(TMO_CYC)};

`ifdef NEO_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_nxt_c;
  assign tmo_nxt_c = (tmo_cnt == {TMO_W{1'b1}}) ? tmo_cnt : tmo_cnt + TMO_W'(1);
`endif

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state      <= S_IDLE;
      spr_req_q  <= 1'b0;
      fix_req_q  <= 1'b0;
      pend_spr   <= 1'b0;
      pend_fix   <= 1'b0;
      last_spr   <= 1'b0;
      gnt_spr    <= 1'b0;
      spr_wa     <= '0;
      fix_wa     <= '0;
      fix_lsb    <= 1'b0;
      fix_lsb_g  <= 1'b0;
      sd_req_q   <= 1'b0;
      sd_addr_q  <= '0;
      spr_data_q <= '0;
      fix_data_q <= '0;
      spr_rdy_q  <= 1'b0;
      fix_rdy_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
`ifdef NEO_ARB_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      spr_req_q <= bus.SPR_REQ;
      fix_req_q <= bus.FIX_REQ;
      spr_rdy_q <= 1'b0;
      fix_rdy_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pend_spr || pend_fix) begin
            gnt_spr   <= sel_spr_c;
            last_spr  <= sel_spr_c;
            sd_req_q  <= 1'b1;
            sd_addr_q <= sel_spr_c ? spr_wa : fix_wa;
            fix_lsb_g <= fix_lsb;
            if (sel_spr_c) pend_spr <= 1'b0;
            else           pend_fix <= 1'b0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.SD_ACK) begin
            sd_req_q <= 1'b0;
`ifdef NEO_ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
            if (bus.SD_VALID) begin
              if (gnt_spr) spr_data_q <= bus.SD_DATA;
              else         fix_data_q <= fix_word_c;
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.SD_VALID) begin
            if (gnt_spr) spr_data_q <= bus.SD_DATA;
            else         fix_data_q <= fix_word_c;
            state <= S_DONE;
          end
`ifdef NEO_ARB_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_nxt_c;
            // Abort returns zero data but still strobes RDY so the fetcher never stalls
            if (tmo_nxt_c == TMO_W'(TMO_CYC)) begin
              if (gnt_spr) spr_data_q <= '0;
              else         fix_data_q <= '0;
              tmo_err_q <= 1'b1;
              state     <= S_DONE;
            end
          end
`endif
        end
        S_DONE: begin
          spr_rdy_q <= gnt_spr;
          fix_rdy_q <= ~gnt_spr;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // A new edge outranks the grant-time clear: latest address wins, one-deep queue
      if (spr_edge_c) begin
        pend_spr <= 1'b1;
        spr_wa   <= spr_wa_c;
      end
      if (fix_edge_c) begin
        pend_fix <= 1'b1;
        fix_wa   <= fix_wa_c;
        fix_lsb  <= bus.FIX_ADDR[0];
      end
    end
  end

  assign bus.SD_REQ   = sd_req_q;
  assign bus.SD_ADDR  = sd_addr_q;
  assign bus.SPR_DATA = spr_data_q;
  assign bus.SPR_RDY  = spr_rdy_q;
  assign bus.FIX_DATA = fix_data_q;
  assign bus.FIX_RDY  = fix_rdy_q;
`ifdef NEO_ARB_TIMEOUT_EN
  assign bus.TMO_ERR  = tmo_err_q;
`else
  assign bus.TMO_ERR  = 1'b0;
`endif

endmodule
